// File: rtl/term_cursor_writer.sv
// rtl/term_cursor_writer.sv - byte stream to text-buffer cell writer with cursor, wrap and row clear
module term_cursor_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk100,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [4:0]        o_cur_row,
    output logic [6:0]        o_cur_col,
    output logic              o_busy,
    output logic              o_overflow
);

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [7:0]        COLS_B    = 8'(COLS);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [0:0] {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_mem [0:3];
    logic [1:0]        r_rd_ptr;
    logic [1:0]        r_wr_ptr;
    logic [2:0]        r_count;
    logic              r_overflow;

    logic [4:0]        r_row;
    logic [6:0]        r_col;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] r_clr_end;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [7:0]        w_byte;
    logic [4:0]        w_adv_row;
    logic [ADDR_W-1:0] w_adv_base;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [7:0]        w_tab;

    logic [4:0]        w_row_nxt;
    logic [6:0]        w_col_nxt;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [7:0]        w_wr_data_nxt;
    logic [ADDR_W-1:0] w_clr_addr_nxt;
    logic [ADDR_W-1:0] w_clr_end_nxt;

    // A full FIFO still accepts a byte when the head is leaving in the same cycle
    assign w_full     = (r_count == 3'd4);
    assign w_push     = i_rx_valid && (!w_full || w_pop);
    assign w_byte     = r_mem[r_rd_ptr];

    // Cursor-derived addresses; the row wraps to the top since there is no scrolling
    assign w_adv_row  = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
    assign w_adv_base = ADDR_W'(w_adv_row) * COLS_A;
    assign w_cur_addr = ADDR_W'(r_row) * COLS_A + ADDR_W'(r_col);
    assign w_tab      = {1'b0, r_col[6:3], 3'b000} + 8'd8;

    // FIFO storage, pointers, occupancy and sticky drop flag
    always_ff @(posedge i_clk100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_rx_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (i_rx_valid && !w_push) r_overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk100 or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Decode and clear sweep; the pop cycle issues the first write so output lands next cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_end_nxt  = r_clr_end;
        case (r_state)
            S_IDLE: begin
                if (r_count != 3'd0) begin
                    w_pop = 1'b1;
                    if (w_byte >= 8'h20 && w_byte <= 8'h7E) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_cur_addr;
                        w_wr_data_nxt = w_byte;
                        if (r_col == LAST_COL) begin
                            w_col_nxt      = 7'd0;
                            w_row_nxt      = w_adv_row;
                            w_clr_addr_nxt = w_adv_base;
                            w_clr_end_nxt  = w_adv_base + COLS_A - ADDR_W'(1);
                            w_state_nxt    = S_CLEAR;
                        end else begin
                            w_col_nxt = r_col + 7'd1;
                        end
                    end else begin
                        case (w_byte)
                            8'h0D: w_col_nxt = 7'd0;
                            8'h0A: begin
                                w_row_nxt      = w_adv_row;
                                w_wr_en_nxt    = 1'b1;
                                w_wr_addr_nxt  = w_adv_base;
                                w_wr_data_nxt  = SPACE;
                                w_clr_addr_nxt = w_adv_base + ADDR_W'(1);
                                w_clr_end_nxt  = w_adv_base + COLS_A - ADDR_W'(1);
                                w_state_nxt    = S_CLEAR;
                            end
                            8'h08: if (r_col != 7'd0) w_col_nxt = r_col - 7'd1;
                            8'h09: w_col_nxt = (w_tab >= COLS_B) ? LAST_COL : w_tab[6:0];
                            8'h0C: begin
                                w_row_nxt      = 5'd0;
                                w_col_nxt      = 7'd0;
                                w_wr_en_nxt    = 1'b1;
                                w_wr_addr_nxt  = '0;
                                w_wr_data_nxt  = SPACE;
                                w_clr_addr_nxt = ADDR_W'(1);
                                w_clr_end_nxt  = LAST_CELL;
                                w_state_nxt    = S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_clr_addr;
                w_wr_data_nxt = SPACE;
                if (r_clr_addr == r_clr_end) w_state_nxt = S_IDLE;
                else                         w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Cursor, registered write port and clear-sweep bounds
    always_ff @(posedge i_clk100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row      <= '0;
            r_col      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_clr_addr <= '0;
            r_clr_end  <= '0;
        end else begin
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_clr_end  <= w_clr_end_nxt;
        end
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_cur_row  = r_row;
    assign o_cur_col  = r_col;
    assign o_busy     = (r_state != S_IDLE) || (r_count != 3'd0);
    assign o_overflow = r_overflow;

endmodule

// File: doc/term_cursor_writer.md
# term_cursor_writer

Byte-to-screen terminal writer between `uart_rx` and `vga_text_mode`. Consumes received bytes (`complete` strobe plus `data`), buffers them in a 4-entry FIFO, interprets printable characters and a small set of control codes, and issues single-cycle character-cell writes (`wr_en`/`wr_addr`/`wr_data`) to the text buffer. Maintains the cursor, wraps at line end and screen bottom, and blanks each newly entered row with spaces.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 25, rows per screen
- `ADDR_W`, 11, text-buffer address width; ROWS*COLS ≤ 2^ADDR_W required

- `clk100`  in  1  system clock, 100 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_data`  in  8  received byte, valid when `rx_valid`
- `rx_valid`  in  1  one-cycle strobe per received byte
- `wr_en`  out  1  text-buffer write strobe, one cycle per cell
- `wr_addr`  out  ADDR_W  cell address = row*COLS + col
- `wr_data`  out  8  character code
- `cur_row`  out  5  cursor row, 0..ROWS-1
- `cur_col`  out  7  cursor column, 0..COLS-1
- `busy`  out  1  FSM not in IDLE, or FIFO not empty
- `overflow`  out  1  sticky: byte dropped due to full FIFO

## Operation
- Reset, asynchronous, active-low (`rst_n` low): all outputs 0, FIFO empty, FSM in IDLE, cursor (0,0). No screen clear on reset.
- FIFO: 4 entries. Push on `rx_valid` if not full, or if full and popping in the same cycle. Otherwise the byte is dropped and `overflow` is set until reset.
- FSM states:
  - IDLE: if FIFO non-empty, pop one byte and decode it.
  - CLEAR: stays in CLEAR until its clear sweep finishes.
- Decode (in IDLE, on pop):
  - 0x20–0x7E: write byte at (row, col). Then col+1; if col was COLS-1, set col=0 and do a line advance.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: line advance; col unchanged.
  - 0x08 BS: if col>0 then col-1; no write, no erase.
  - 0x09 TAB: col = next multiple of 8; if that is ≥ COLS, col = COLS-1. No write.
  - 0x0C FF: full-screen clear, cursor to (0,0).
  - All other bytes: ignored, consumed in one cycle.
- Line advance: row = (row==ROWS-1) ? 0 : row+1. Then enter CLEAR for the new row: COLS writes of 0x20 at addresses row*COLS .. row*COLS+COLS-1, ascending. No scrolling.
- Full-screen clear: ROWS*COLS writes of 0x20 at addresses 0 .. ROWS*COLS-1, ascending. Then IDLE with cursor (0,0).
- Address arithmetic: computed at ADDR_W bits; no truncation for legal parameters.
- `cur_row`/`cur_col` update on the same edge as the first write or state change caused by the byte.

## Timing
- `rx_valid` high in cycle T: FIFO holds the byte after edge T. With FIFO empty and FSM in IDLE, pop and decode happen in cycle T+1. `wr_en` is high during cycle T+2.
- Printable byte: exactly one `wr_en` cycle. Back-to-back printable bytes in the FIFO produce writes on consecutive cycles, one per cycle.
- Printable byte at col COLS-1: character write in cycle N. Row-clear writes occupy cycles N+1..N+COLS. Next pop at N+COLS.
- LF: clear writes start the cycle after the pop, with COLS consecutive `wr_en` cycles.
- FF: ROWS*COLS consecutive `wr_en` cycles (2000 at defaults).
- `wr_en` is never high in IDLE without a preceding pop. `wr_addr`/`wr_data` are stable whenever `wr_en` is high.
- FIFO keeps accepting bytes during CLEAR.
- `rst_n` asserted mid-CLEAR: `wr_en` drops immediately (async), the clear is abandoned, and FIFO contents are lost.

## Test plan
- Reset, then send 'A','B': writes (addr 0, 0x41) and (addr 1, 0x42). `wr_en` first high 2 cycles after the first `rx_valid`. Cursor ends at (0,2).
- 80 × 'x' from (0,0): 80 writes at addr 0..79. Then 80 writes of 0x20 at 80..159. Cursor (1,0).
- Cursor at (24,5), send LF: 80 writes of 0x20 at addr 0..79, cursor (0,5). Then CR, 'Z': write (addr 0, 0x5A).
- TAB from col 3 → col 8. TAB from col 78 → col 79. BS at col 0 → col 0. BS at col 8 → col 7. None of these cause a write. Byte 0x07 is ignored.
- FF: 2000 consecutive writes of 0x20 at addr 0..1999, cursor (0,0). 6 `rx_valid` strobes during the clear: 4 bytes kept, 2 dropped, `overflow`=1. The 4 kept bytes are written after the clear, in order.
- `rst_n` low for 1 cycle mid-LF-clear: `wr_en`=0, `overflow`=0, cursor (0,0), `busy`=0.
